freqchng_divgen: RTL and testbench

//  Parametrised, runtime-switchable multi-channel clock divider; successor to the fixed PLL freq-change generator.

---
 rtl/freqchng_divgen.sv | 161 ++++++++++++++++
 tb/tb_freqchng_divgen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/freqchng_divgen.sv
// freqchng_divgen: runtime-switchable N-channel clock divider with glitch-free low/high mode change.
// Optional per-channel phase-offset preload is compiled in when FREQCHNG_PHASE_OFS_EN is defined.
module freqchng_divgen #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 8,
    parameter int SETTLE = 4
) (
    input  logic                  CLK_IN,
    input  logic                  RESET_N,
    input  logic [N_CH*CNT_W-1:0] DIV_LO,
    input  logic [N_CH*CNT_W-1:0] DIV_HI,
`ifdef FREQCHNG_PHASE_OFS_EN
    input  logic [N_CH*CNT_W-1:0] PHASE_OFS,
`endif
    input  logic                  REQ_VALID,
    input  logic                  REQ_MODE,
    output logic                  REQ_READY,
    output logic [N_CH-1:0]       CLK_OUT,
    output logic                  LOCKED,
    output logic                  FLAG_HIGH_FREQ
);
    localparam int SC_W = $clog2(SETTLE + 1);

    localparam logic [1:0] ST_SWITCH = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  pend_q, pend_d;
    logic                  locked_q, locked_d;
    logic                  ready_q, ready_d;
    logic [SC_W-1:0]       rise_cnt_q, rise_cnt_d;
    logic [N_CH-1:0]       clk_q, clk_d;
    logic [N_CH*CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH*CNT_W-1:0] div_lo_q, div_lo_d;
    logic [N_CH*CNT_W-1:0] div_hi_q, div_hi_d;
    logic [CNT_W-1:0]      h_cur;
`ifdef FREQCHNG_PHASE_OFS_EN
    logic [CNT_W-1:0]      h_new;
`endif

    // A programmed half-period of zero behaves as one cycle.
    function automatic logic [CNT_W-1:0] eff_half(input logic [CNT_W-1:0] div);
        return (div == '0) ? CNT_W'(1) : div;
    endfunction

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pend_d     = pend_q;
        locked_d   = locked_q;
        ready_d    = ready_q;
        rise_cnt_d = rise_cnt_q;
        clk_d      = clk_q;
        cnt_d      = cnt_q;
        div_lo_d   = div_lo_q;
        div_hi_d   = div_hi_q;
        h_cur      = '0;
`ifdef FREQCHNG_PHASE_OFS_EN
        h_new      = '0;
`endif

        // While draining, a channel that is low parks immediately; a high one finishes its full half-period.
        if (state_q != ST_SWITCH) begin
            for (int i = 0; i < N_CH; i++) begin
                h_cur = eff_half(mode_q ? div_hi_q[i*CNT_W +: CNT_W] : div_lo_q[i*CNT_W +: CNT_W]);
                if (state_q == ST_DRAIN && !clk_q[i]) begin
                    cnt_d[i*CNT_W +: CNT_W] = '0;
                end else if (cnt_q[i*CNT_W +: CNT_W] == h_cur - CNT_W'(1)) begin
                    cnt_d[i*CNT_W +: CNT_W] = '0;
                    clk_d[i]                = ~clk_q[i];
                end else begin
                    cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end

        case (state_q)
            ST_SWITCH: begin
                mode_d     = pend_q;
                div_lo_d   = DIV_LO;
                div_hi_d   = DIV_HI;
                clk_d      = '0;
                rise_cnt_d = '0;
                locked_d   = 1'b0;
                ready_d    = 1'b0;
                state_d    = ST_SETTLE;
`ifdef FREQCHNG_PHASE_OFS_EN
                for (int i = 0; i < N_CH; i++) begin
                    h_new = eff_half(pend_q ? DIV_HI[i*CNT_W +: CNT_W] : DIV_LO[i*CNT_W +: CNT_W]);
                    cnt_d[i*CNT_W +: CNT_W] = (PHASE_OFS[i*CNT_W +: CNT_W] < h_new) ?
                                              PHASE_OFS[i*CNT_W +: CNT_W] : h_new - CNT_W'(1);
                end
`else
                cnt_d = '0;
`endif
            end
            ST_SETTLE: begin
                if (!clk_q[0] && clk_d[0]) begin
                    if (rise_cnt_q == SC_W'(SETTLE - 1)) begin
                        state_d  = ST_IDLE;
                        locked_d = 1'b1;
                        ready_d  = 1'b1;
                    end else begin
                        rise_cnt_d = rise_cnt_q + SC_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                if (REQ_VALID && ready_q && (REQ_MODE != mode_q)) begin
                    pend_d   = REQ_MODE;
                    state_d  = ST_DRAIN;
                    locked_d = 1'b0;
                    ready_d  = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (clk_d == '0) begin
                    state_d = ST_SWITCH;
                end
            end
            default: state_d = ST_SWITCH;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_SWITCH;
            mode_q     <= 1'b0;
            pend_q     <= 1'b0;
            locked_q   <= 1'b0;
            ready_q    <= 1'b0;
            rise_cnt_q <= '0;
            clk_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            locked_q   <= locked_d;
            ready_q    <= ready_d;
            rise_cnt_q <= rise_cnt_d;
            clk_q      <= clk_d;
            cnt_q      <= cnt_d;
        end
    end

    // Divider settings are always loaded in SWITCH before use, so they carry no reset.
    always_ff @(posedge CLK_IN) begin
        div_lo_q <= div_lo_d;
        div_hi_q <= div_hi_d;
    end

    assign CLK_OUT        = clk_q;
    assign LOCKED         = locked_q;
    assign REQ_READY      = ready_q;
    assign FLAG_HIGH_FREQ = mode_q;

endmodule

// File: tb/tb_freqchng_divgen.sv
// tb_freqchng_divgen: directed + randomized bench; a closed-form waveform model feeds a per-edge scoreboard.
module tb_freqchng_divgen;
    localparam int N_CH   = 2;
    localparam int CNT_W  = 4;
    localparam int SETTLE = 4;
    localparam int VW     = N_CH + 3;

    logic                  CLK_IN    = 1'b0;
    logic                  RESET_N   = 1'b0;
    logic [N_CH*CNT_W-1:0] DIV_LO    = 8'h24;
    logic [N_CH*CNT_W-1:0] DIV_HI    = 8'h11;
    logic                  REQ_VALID = 1'b0;
    logic                  REQ_MODE  = 1'b0;
    logic                  REQ_READY;
    logic [N_CH-1:0]       CLK_OUT;
    logic                  LOCKED;
    logic                  FLAG_HIGH_FREQ;
`ifdef FREQCHNG_PHASE_OFS_EN
    logic [N_CH*CNT_W-1:0] PHASE_OFS = '0;
`endif

    freqchng_divgen #(.N_CH(N_CH), .CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
        .CLK_IN         (CLK_IN),
        .RESET_N        (RESET_N),
        .DIV_LO         (DIV_LO),
        .DIV_HI         (DIV_HI),
`ifdef FREQCHNG_PHASE_OFS_EN
        .PHASE_OFS      (PHASE_OFS),
`endif
        .REQ_VALID      (REQ_VALID),
        .REQ_MODE       (REQ_MODE),
        .REQ_READY      (REQ_READY),
        .CLK_OUT        (CLK_OUT),
        .LOCKED         (LOCKED),
        .FLAG_HIGH_FREQ (FLAG_HIGH_FREQ)
    );

    always #5 CLK_IN = ~CLK_IN;

    int tests = 0;
    int fails = 0;

    logic [VW-1:0] sb_q[$];
    int            edge_q[$];

    // Reference model: outputs are a closed-form function of the edge count since the last switch.
    int            n         = 0;
    bit            m_rst     = 1'b1;
    int            sw        = 0;
    bit            mode_cur  = 1'b0;
    int            h[N_CH]   = '{default: 1};
    bit            drn       = 1'b0;
    int            acc       = 0;
    int            next_sw   = 0;
    bit            pend_mode = 1'b0;
    bit            hi_acc[N_CH];
    int            fall[N_CH];
    logic [VW-1:0] exp_last  = '0;

    function automatic int eff_h(input logic [CNT_W-1:0] d);
        return (d == '0) ? 1 : int'(d);
    endfunction

    function void start_switch(input int at, input bit md);
        sw       = at;
        mode_cur = md;
        drn      = 1'b0;
        for (int i = 0; i < N_CH; i++)
            h[i] = eff_h(md ? DIV_HI[i*CNT_W +: CNT_W] : DIV_LO[i*CNT_W +: CNT_W]);
    endfunction

    function automatic bit run_clk(input int i, input int at);
        return (((at - sw) / h[i]) % 2) == 1;
    endfunction

    function automatic bit idle_after(input int at);
        return !drn && !m_rst && (at >= sw) && ((at - sw) >= (2 * SETTLE - 1) * h[0]);
    endfunction

    function automatic logic [VW-1:0] predict(input int at);
        logic [N_CH-1:0] c;
        logic            lk;
        if (m_rst) return '0;
        lk = idle_after(at);
        for (int i = 0; i < N_CH; i++)
            c[i] = (drn && at > acc) ? (hi_acc[i] && at < fall[i]) : run_clk(i, at);
        return {lk, lk, mode_cur, c};
    endfunction

    task automatic model_step();
        int e_end;
        if (!RESET_N) begin
            m_rst = 1'b1;
            drn   = 1'b0;
        end else if (m_rst) begin
            m_rst = 1'b0;
            start_switch(n, 1'b0);
        end else if (drn && n == next_sw) begin
            start_switch(n, pend_mode);
        end else if (REQ_VALID && REQ_MODE != mode_cur && idle_after(n - 1)) begin
            drn       = 1'b1;
            acc       = n;
            pend_mode = REQ_MODE;
            e_end     = n + 1;
            for (int i = 0; i < N_CH; i++) begin
                hi_acc[i] = run_clk(i, n);
                fall[i]   = sw + ((n - sw) / h[i] + 1) * h[i];
                if (hi_acc[i] && fall[i] > e_end) e_end = fall[i];
            end
            next_sw = e_end + 1;
        end
    endtask

    task automatic cycle();
        @(posedge CLK_IN);
        n++;
        model_step();
        exp_last = predict(n);
        sb_q.push_back(exp_last);
        edge_q.push_back(n);
        #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic run(input int k);
        repeat (k) cycle();
    endtask

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %b want %b", name, act, want);
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k;
        k = 0;
        while (!idle_after(n) && k < max) begin
            cycle();
            k++;
        end
        chk(tag, VW'(LOCKED), VW'(1'b1));
    endtask

    task automatic request(input bit md);
        REQ_VALID = 1'b1;
        REQ_MODE  = md;
        cycle();
    endtask

    function automatic logic [N_CH*CNT_W-1:0] rand_div();
        logic [N_CH*CNT_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 5));
        return v;
    endfunction

    // Monitor: one expected entry per clock edge, compared on the falling edge.
    initial begin
        logic [VW-1:0] e;
        logic [VW-1:0] act;
        int            en;
        forever begin
            @(negedge CLK_IN);
            act = {REQ_READY, LOCKED, FLAG_HIGH_FREQ, CLK_OUT};
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_empty: got %b with no expected entry at t=%0t", act, $time);
            end else begin
                e  = sb_q.pop_front();
                en = edge_q.pop_front();
                if (act !== e) begin
                    fails++;
                    $display("FAIL edge%0d rdy/lk/flag/clk: got %b want %b", en, act, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t want < 100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev;
        int   k;

        run(3);
        RESET_N = 1'b1;
        wait_idle("lock_after_reset", 100);
        chk("flag_lo_after_reset", VW'(FLAG_HIGH_FREQ), VW'(1'b0));

        request(1'b1);
        chk("accept_drops_rdy_lk", VW'({REQ_READY, LOCKED}), VW'(2'b00));
        wait_idle("lock_high", 100);
        chk("flag_high", VW'(FLAG_HIGH_FREQ), VW'(1'b1));

        request(1'b1);
        chk("noop_keeps_rdy_lk", VW'({REQ_READY, LOCKED}), VW'(2'b11));
        run(5);

        request(1'b0);
        for (int i = 0; i < 12; i++) begin
            if (!idle_after(n)) begin
                REQ_VALID = 1'b1;
                REQ_MODE  = 1'b1;
            end
            cycle();
        end
        wait_idle("lock_after_ignored_req", 100);
        chk("flag_after_ignored_req", VW'(FLAG_HIGH_FREQ), VW'(1'b0));

        DIV_LO = 8'h20;
        request(1'b1);
        wait_idle("lock_high2", 100);
        request(1'b0);
        wait_idle("lock_div0", 100);
        run(6);

        DIV_LO = 8'h24;
        request(1'b1);
        wait_idle("lock_high3", 100);
        request(1'b0);
        wait_idle("lock_low3", 100);

        prev = exp_last[0];
        cycle();
        k = 0;
        while (!(exp_last[0] && !prev) && k < 20) begin
            prev = exp_last[0];
            cycle();
            k++;
        end
        request(1'b1);
        cycle();
        chk("drain_ch0_high", VW'(CLK_OUT[0]), VW'(exp_last[0]));
        @(negedge CLK_IN);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("async_reset_mid_drain", {REQ_READY, LOCKED, FLAG_HIGH_FREQ, CLK_OUT}, '0);
        run(2);
        RESET_N = 1'b1;
        wait_idle("relock_after_reset", 100);
        chk("flag_after_relock", VW'(FLAG_HIGH_FREQ), VW'(1'b0));

        for (int c = 0; c < 700; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                DIV_LO = rand_div();
                DIV_HI = rand_div();
            end
            if ($urandom_range(0, 5) == 0) begin
                REQ_VALID = 1'b1;
                REQ_MODE  = 1'($urandom_range(0, 1));
            end
            cycle();
        end

        @(negedge CLK_IN);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
